// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I-subset core: steps the shared-memory
// datapath through fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op_code,
  input  logic [2:0]       func3,
  input  logic             func7b6,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             halt,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL
  } state_t;

  state_t     state, state_next;
  logic       mem_req_d, mem_write_d, ir_write_d, pc_write_d, reg_write_d, halt_d;
  logic       retire;
  logic [2:0] alu_fn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  // func7b6 only selects subtract for register-register ops (op_code[5] set)
  always_comb begin
    alu_fn = 3'b000;
    case (func3)
      3'b000:  alu_fn = (op_code[5] & func7b6) ? 3'b001 : 3'b000;
      3'b010:  alu_fn = 3'b101;
      3'b110:  alu_fn = 3'b011;
      3'b111:  alu_fn = 3'b010;
      default: alu_fn = 3'b000;
    endcase
  end

  always_comb begin
    state_next  = state;
    mem_req_d   = 1'b0;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    pc_write_d  = 1'b0;
    reg_write_d = 1'b0;
    halt_d      = 1'b0;
    retire      = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    imm_src     = 2'b00;
    result_src  = 2'b00;
    case (state)
      FETCH: begin
        mem_req_d  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_d = mem_ready;
        pc_write_d = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
        case (op_code)
          7'b0000011, 7'b0100011: state_next = MEMADR;
          7'b0110011:             state_next = EXECR;
          7'b0010011:             state_next = EXECI;
          7'b1100011:             state_next = BEQ;
          7'b1101111:             state_next = JAL;
          default:                state_next = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = op_code[5] ? 2'b01 : 2'b00;
        state_next = op_code[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req_d = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src  = 2'b01;
        reg_write_d = 1'b1;
        retire      = 1'b1;
        state_next  = FETCH;
      end
      MEMWRITE: begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b1;
        adr_src     = 1'b1;
        retire      = mem_ready;
        if (mem_ready) state_next = FETCH;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_fn;
        state_next  = ALUWB;
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_fn;
        state_next  = ALUWB;
      end
      ALUWB: begin
        reg_write_d = 1'b1;
        retire      = 1'b1;
        state_next  = FETCH;
      end
      BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write_d  = zero;
        retire      = 1'b1;
        state_next  = FETCH;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_d = 1'b1;
        state_next = ALUWB;
      end
      ILLEGAL: begin
        halt_d = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Enables are masked while reset is held so nothing writes during reset
  assign mem_req   = reset & mem_req_d;
  assign mem_write = reset & mem_write_d;
  assign ir_write  = reset & ir_write_d;
  assign pc_write  = reset & pc_write_d;
  assign reg_write = reset & reg_write_d;
  assign halt      = reset & halt_d;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into its expected per-cycle control plan
// and the DUT outputs are compared against that plan every cycle.
module tb_multicycle_controller;

  logic        clk, reset;
  logic [6:0]  op_code;
  logic [2:0]  func3;
  logic        func7b6, zero, mem_ready;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, halt;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0]  alu_control;
  logic [31:0] instret;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .func3(func3), .func7b6(func7b6),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .result_src(result_src), .halt(halt), .instret(instret)
  );

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] a, b;
    logic [2:0] alu;
    logic [1:0] imm, res;
    logic       halt;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic mr, z, ret;
  } cyc_t;

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned cyc_n = 0;
  int unsigned stamps[$];
  logic        exp_valid;
  ctl_t        exp_c;
  logic [31:0] exp_cnt, model_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc_n++;
    if (exp_valid) begin
      ctl_t act;
      act = '{mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
              alu_src_a, alu_src_b, alu_control, imm_src, result_src, halt};
      chk("ctl", 64'(act), 64'(exp_c));
      chk("instret", 64'(instret), 64'(exp_cnt));
      if (ir_write === 1'b1) stamps.push_back(cyc_n);
    end
  end

  function automatic ctl_t mk(input logic mq, mw, ad, iw, pw, rw, input logic [1:0] a, b,
                              input logic [2:0] alu, input logic [1:0] imm, res, input logic h);
    return '{mq, mw, ad, iw, pw, rw, a, b, alu, imm, res, h};
  endfunction

  function automatic cyc_t cy(input ctl_t c, input logic mr, input logic z, input logic ret);
    return '{c, mr, z, ret};
  endfunction

  function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (op[5] && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  task automatic drive(input cyc_t x);
    mem_ready = x.mr;
    zero      = x.z;
    exp_c     = x.c;
    exp_cnt   = model_cnt;
    exp_valid = 1'b1;
    @(posedge clk);
    if (x.ret) model_cnt = model_cnt + 32'd1;
    #1;
  endtask

  task automatic do_reset();
    exp_valid = 1'b0;
    reset     = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_enables", 64'({mem_req, mem_write, ir_write, pc_write, reg_write, halt}), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    model_cnt = '0;
  endtask

  // abort != 0 stops the plan after that many cycles (instruction abandoned)
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int unsigned fst, input int unsigned mst,
                           input int unsigned abort);
    cyc_t q[$];
    ctl_t cm;
    op_code = op; func3 = f3; func7b6 = f7;
    for (int unsigned i = 0; i < fst; i++)
      q.push_back(cy(mk(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b00,2'b10,0), 1'b0, rb(), 1'b0));
    q.push_back(cy(mk(1,0,0,1,1,0,2'b00,2'b10,3'b000,2'b00,2'b10,0), 1'b1, rb(), 1'b0));
    q.push_back(cy(mk(0,0,0,0,0,0,2'b01,2'b01,3'b000,2'b10,2'b00,0), rb(), rb(), 1'b0));
    case (op)
      7'b0000011, 7'b0100011: begin
        q.push_back(cy(mk(0,0,0,0,0,0,2'b10,2'b01,3'b000,op[5] ? 2'b01 : 2'b00,2'b00,0),
                       rb(), rb(), 1'b0));
        cm = op[5] ? mk(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0)
                   : mk(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0);
        for (int unsigned i = 0; i < mst; i++) q.push_back(cy(cm, 1'b0, rb(), 1'b0));
        q.push_back(cy(cm, 1'b1, rb(), op[5]));
        if (!op[5])
          q.push_back(cy(mk(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,2'b01,0), rb(), rb(), 1'b1));
      end
      7'b0110011, 7'b0010011: begin
        q.push_back(cy(mk(0,0,0,0,0,0,2'b10,op[5] ? 2'b00 : 2'b01,exp_alu(op, f3, f7),2'b00,2'b00,0),
                       rb(), rb(), 1'b0));
        q.push_back(cy(mk(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,2'b00,0), rb(), rb(), 1'b1));
      end
      7'b1100011:
        q.push_back(cy(mk(0,0,0,0,z,0,2'b10,2'b00,3'b001,2'b00,2'b00,0), rb(), z, 1'b1));
      7'b1101111: begin
        q.push_back(cy(mk(0,0,0,0,1,0,2'b01,2'b10,3'b000,2'b00,2'b00,0), rb(), rb(), 1'b0));
        q.push_back(cy(mk(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,2'b00,0), rb(), rb(), 1'b1));
      end
      default:
        for (int unsigned i = 0; i < 22; i++)
          q.push_back(cy(mk(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,1), rb(), rb(), 1'b0));
    endcase
    for (int unsigned i = 0; i < q.size(); i++) begin
      if (abort != 0 && i == abort) break;
      drive(q[i]);
    end
  endtask

  function automatic logic legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  initial begin
    logic [6:0] op;
    int unsigned k;
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    op_code = '0; func3 = '0; func7b6 = 1'b0;
    exp_valid = 1'b0; exp_c = '0; exp_cnt = '0; model_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 0);
    chk("instret_after_rr", 64'(instret), 64'd2);

    stamps.delete();
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, 0);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 0);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 0);
    chk("fetch_count", 64'(stamps.size()), 64'd5);
    if (stamps.size() >= 5) begin
      chk("lw_stall3_cycles", 64'(stamps[1] - stamps[0]), 64'd8);
      chk("beq_z1_cycles",    64'(stamps[2] - stamps[1]), 64'd3);
      chk("beq_z0_cycles",    64'(stamps[3] - stamps[2]), 64'd3);
      chk("jal_cycles",       64'(stamps[4] - stamps[3]), 64'd4);
    end
    chk("instret_after_dir", 64'(instret), 64'd7);

    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    do_reset();

    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2, 4);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 19);
      case (k)
        0, 1, 2:       op = 7'b0000011;
        3, 4, 5:       op = 7'b0100011;
        6, 7, 8, 9:    op = 7'b0110011;
        10, 11, 12, 13: op = 7'b0010011;
        14, 15, 16:    op = 7'b1100011;
        17, 18:        op = 7'b1101111;
        default: begin
          op = 7'($urandom);
          while (legal(op)) op = 7'($urandom);
        end
      endcase
      run_instr(op, 3'($urandom), rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 2), 0);
      if (!legal(op)) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
